apb4_sram_slave: RTL and testbench
==================================

// Module: apb4_sram_slave
// PURPOSE
// - APB4 slave with an internal single-port word memory; parametrised successor to the APB3 SRAM slave.
// - Adds byte-lane writes (pstrb), configurable read/write wait states, and error response (pslverr).
// - Adds generic data width; memory contents survive reset.
// - Sits on the peripheral APB bus as the scratch/config RAM; one outstanding transfer, no pipelining.
// PARAMETERS
// DATA_BYTES  4     bytes per word (1,2,4,8); DW=8*DATA_BYTES, AL=$clog2(DATA_BYTES)
// ADDR_BITS   10    word-index bits
// MEM_DEPTH   1024  words implemented (<= 2**ADDR_BITS); higher indices error
// RD_LAT      1     read wait states (1..4), models the SRAM output pipeline
// WR_WAIT     0     write wait states (0..3)
// PORTS
// clk      in   1              clock, all logic on rising edge
// rstn     in   1              asynchronous, active-low reset
// paddr    in   ADDR_BITS+AL   byte address; word index = paddr[AL +: ADDR_BITS]
// psel     in   1              slave select
// penable  in   1              access phase
// pwrite   in   1              1 write, 0 read
// pwdata   in   DW             write data
// pstrb    in   DATA_BYTES     write byte strobes, bit i -> pwdata[8i+7:8i]
// pprot    in   3              accepted, ignored
// pready   out  1              transfer complete, registered
// prdata   out  DW             read data, registered, valid when pready & !pwrite
// pslverr  out  1              error response, valid only with pready
// BEHAVIOUR
// - Reset: pready=0, pslverr=0, prdata=0, FSM=IDLE, counters 0; memory array NOT cleared.
// - Setup detect: psel & !penable in IDLE. At that edge, latch the following:
//   - word index, pwrite, pwdata, pstrb
//   - err = (paddr[AL-1:0]!=0) | (index>=MEM_DEPTH)
// - Wait states N: err -> 0; write -> WR_WAIT; read -> RD_LAT.
// - FSM IDLE -> WAIT (N>0, cnt=N-1) or RESP (N==0).
// - WAIT decrements cnt each cycle; cnt==0 -> RESP.
// - RESP drives pready=1 for exactly one cycle, then returns to IDLE.
// - Timing: setup cycle T1; pready high in access cycle T(2+N); deasserted the cycle after.
//   - Example: RD_LAT=1 read gives pready in T3.
// - Back-to-back: a new setup is accepted in the cycle after pready. No idle cycle is required.
// - Write commit: at the edge ending the pready cycle, lanes with pstrb[i]=1 update; the others keep their value.
//   - pstrb=0 -> no change, OKAY response.
// - Read: memory read uses the latched index; prdata loads at the edge that raises pready.
//   - prdata holds its value until the next read completes. Writes do not change prdata.
// - Error: no memory access (write suppressed); pslverr=1 with pready; prdata loads 0 for an error read.
// - pslverr=0 whenever pready=0.
// - Write then read of the same word in consecutive transfers returns the new data (no hazard).
// - psel low while in WAIT/RESP: abort to IDLE next cycle; pready=0; write not committed.
// - penable high while in IDLE without a prior setup: ignored; no response generated.
// - Address/data/strobe changes during WAIT are ignored; the latched values are used.
// - Reset asserted mid-transfer: immediate return to IDLE; outputs to reset values.
//   - A write commits only if its pready edge already occurred; other memory words are untouched.
// TESTING
// 1 Default params: write 0xDEADBEEF @0x010 strb=4'hF, read @0x010 -> pready in T2 (write), T3 (read); prdata=0xDEADBEEF, pslverr=0.
// 2 Byte lanes: write 0x11223344 @0x020, write 0xAABBCCDD strb=4'b0101, read -> 0x11BB33DD.
// 3 Errors: read @0x013 (misaligned) and, with MEM_DEPTH=512, write @0x800 -> pready in T2, pslverr=1, prdata=0, word 512 alias not written.
// 4 Latency sweep: RD_LAT=3, WR_WAIT=2 -> read pready in T5, write pready in T4; back-to-back write/read same word returns written data.
// 5 Abort/reset: drop psel during write WAIT -> memory unchanged; assert rstn=0 mid read -> pready/pslverr/prdata=0, earlier data still readable after reset.
// 6 Random APB4 traffic against a byte-masked reference model, 10k transfers, all params legal -> zero mismatches.

Source files
------------

// File: rtl/apb4_sram_slave.sv
// APB4 slave fronting a single-port word SRAM: byte-lane writes, parametrised read/write
// wait states, pslverr for misaligned or out-of-range addresses; one transfer in flight.
module apb4_sram_slave #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_BITS  = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LAT     = 1,
  parameter int WR_WAIT    = 0,
  localparam int DW = 8 * DATA_BYTES,
  localparam int AL = $clog2(DATA_BYTES),
  localparam int AW = ADDR_BITS + AL
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [AW-1:0]         paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DW-1:0]         pwdata,
  input  logic [DATA_BYTES-1:0] pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DW-1:0]         prdata,
  output logic                  pslverr
);

  localparam int MI = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW-1:0]      ALIGN_MASK = AW'(DATA_BYTES - 1);
  localparam logic [ADDR_BITS:0] DEPTH      = (ADDR_BITS + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]  idx_q;
  logic                  wr_q, err_q;
  logic [DW-1:0]         wdata_q;
  logic [DATA_BYTES-1:0] strb_q;
  logic [DW-1:0]         mem [MEM_DEPTH];

  logic                  setup, load, commit;
  logic                  err_now, err_sel, wr_sel;
  logic [ADDR_BITS-1:0]  idx_now;
  logic [2:0]            n_now;
  logic                  unused_ok;

  assign unused_ok = ^{pprot, idx_q};

  assign setup   = psel && !penable;
  assign idx_now = paddr[AL +: ADDR_BITS];
  assign err_now = (|(paddr & ALIGN_MASK)) || ({1'b0, idx_now} >= DEPTH);
  assign n_now   = err_now ? 3'd0 : (pwrite ? 3'(WR_WAIT) : 3'(RD_LAT));

  // The response for a zero-wait transfer is decided in the setup cycle itself,
  // so outputs take the live request in IDLE and the latched one afterwards.
  assign err_sel = (state == IDLE) ? err_now : err_q;
  assign wr_sel  = (state == IDLE) ? pwrite  : wr_q;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          load = 1'b1;
          if (n_now == 3'd0) begin
            nxt = RESP;
          end else begin
            nxt     = WAIT;
            cnt_nxt = n_now - 3'd1;
          end
        end
      end
      WAIT: begin
        if (!psel)             nxt = IDLE;
        else if (cnt == 3'd0)  nxt = RESP;
        else                   cnt_nxt = cnt - 3'd1;
      end
      RESP: begin
        nxt    = IDLE;
        commit = psel && wr_q && !err_q;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      pready  <= (nxt == RESP);
      pslverr <= (nxt == RESP) && err_sel;
      if (nxt == RESP && !wr_sel)
        prdata <= err_sel ? '0 : mem[idx_q[MI-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (load) begin
      idx_q   <= idx_now;
      wr_q    <= pwrite;
      err_q   <= err_now;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  // Storage is deliberately outside the reset domain: contents survive rstn.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (strb_q[i])
          mem[idx_q[MI-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_sram_slave.sv
// Bench for apb4_sram_slave: two instances (default and deep-latency/short-depth),
// a byte-level memory model with per-cycle output checking, plus directed literal checks.
`timescale 1ns/1ps
module tb_apb4_sram_slave;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] paddr;
  logic        psel0, psel1, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] prdata0, prdata1;

  always #5 clk = ~clk;

  apb4_sram_slave dut0 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  apb4_sram_slave #(.MEM_DEPTH(512), .RD_LAT(3), .WR_WAIT(2)) dut1 (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready1), .prdata(prdata1), .pslverr(pslverr1)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: per-instance parameters, word memory, pending transfer, expected pready cycle.
  int          depth [2] = '{1024, 512};
  int          rlat  [2] = '{1, 3};
  int          wwait [2] = '{0, 2};
  logic [31:0] mm    [2][1024];
  int          exp_rdy [2] = '{-1, -1};
  bit          p_wr  [2];
  bit          p_err [2];
  int          p_idx [2];
  logic [31:0] p_dat [2];
  logic [3:0]  p_strb[2];
  logic [31:0] pd_exp[2] = '{32'h0, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        bit hit;
        hit = rstn && (cyc == exp_rdy[d]);
        if (!rstn) pd_exp[d] = 32'h0;
        if (hit) begin
          if (p_wr[d] && !p_err[d])
            for (int b = 0; b < 4; b++)
              if (p_strb[d][b]) mm[d][p_idx[d]][8*b +: 8] = p_dat[d][8*b +: 8];
          if (!p_wr[d]) pd_exp[d] = p_err[d] ? 32'h0 : mm[d][p_idx[d]];
        end
        chk($sformatf("pready%0d", d), (d == 0) ? pready0 : pready1, hit);
        chk($sformatf("pslverr%0d", d), (d == 0) ? pslverr0 : pslverr1, hit && p_err[d]);
        chk($sformatf("prdata%0d", d), (d == 0) ? prdata0 : prdata1, pd_exp[d]);
      end
    end
  end

  function automatic bit rdy(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  task automatic idle(input int n);
    psel0 = 0; psel1 = 0; penable = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the current cycle becomes the setup cycle T1.
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output int tidx, output logic [31:0] rd, output logic er);
    int c1, n;
    bit e;
    psel0 = (d == 0); psel1 = (d == 1);
    penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = 3'($urandom);
    c1 = cyc;
    e = (a[1:0] != 2'b00) || (int'(a[11:2]) >= depth[d]);
    n = e ? 0 : (wr ? wwait[d] : rlat[d]);
    p_wr[d] = wr; p_err[d] = e; p_idx[d] = int'(a[11:2]); p_dat[d] = wd; p_strb[d] = st;
    exp_rdy[d] = c1 + 1 + n;
    tidx = -1; rd = 'x; er = 'x;
    @(posedge clk); #1 penable = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rdy(d)) begin
        tidx = cyc - c1 + 1;
        rd   = (d == 0) ? prdata0 : prdata1;
        er   = (d == 0) ? pslverr0 : pslverr1;
        break;
      end
      @(posedge clk); #1;
      paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
    end
    if (tidx < 0) begin
      n_tot++;
      $display("FAIL xfer_timeout dut%0d: no pready within 12 cycles, required in T%0d", d, n + 2);
      exp_rdy[d] = -1;
      psel0 = 0; psel1 = 0; penable = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          t, d;
    logic [31:0] r;
    logic        e;
    bit          w;
    logic [11:0] a;
    psel0 = 0; psel1 = 0; penable = 0; pwrite = 0; paddr = 0;
    pwdata = 0; pstrb = 0; pprot = 0; rstn = 0;

    repeat (3) @(posedge clk);
    #1 chk_on = 1;
    @(negedge clk);
    chk("rst_pready0", pready0, 1'b0);
    chk("rst_prdata1", prdata1, 32'h0);
    chk("rst_pslverr1", pslverr1, 1'b0);
    @(posedge clk); #1 rstn = 1;

    for (int i = 0; i < 1024; i++) xfer(0, 1, 12'(i * 4), 32'h5A00_0000 | i, 4'hF, t, r, e);
    for (int i = 0; i < 512; i++)  xfer(1, 1, 12'(i * 4), 32'hA500_0000 | i, 4'hF, t, r, e);
    idle(1);

    // default parameters: write T2, read T3
    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, t, r, e);
    chk("t1_wr_T", t, 2);
    chk("t1_wr_err", e, 1'b0);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, t, r, e);
    chk("t1_rd_T", t, 3);
    chk("t1_rd_data", r, 32'hDEADBEEF);
    chk("t1_rd_err", e, 1'b0);

    // byte lanes and the all-zero strobe
    xfer(0, 1, 12'h020, 32'h11223344, 4'hF, t, r, e);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101, t, r, e);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, t, r, e);
    chk("t2_lanes", r, 32'h11BB33DD);
    xfer(0, 1, 12'h020, 32'hFFFFFFFF, 4'h0, t, r, e);
    chk("t2_strb0_err", e, 1'b0);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, t, r, e);
    chk("t2_strb0_data", r, 32'h11BB33DD);

    // errors: misaligned read, write beyond MEM_DEPTH
    xfer(0, 0, 12'h013, 32'h0, 4'h0, t, r, e);
    chk("t3_mis_T", t, 2);
    chk("t3_mis_err", e, 1'b1);
    chk("t3_mis_data", r, 32'h0);
    xfer(1, 1, 12'h800, 32'hCAFEF00D, 4'hF, t, r, e);
    chk("t3_oor_T", t, 2);
    chk("t3_oor_err", e, 1'b1);
    xfer(1, 0, 12'h000, 32'h0, 4'h0, t, r, e);
    chk("t3_alias_data", r, 32'hA500_0000);

    // long latencies, back-to-back write then read of one word
    xfer(1, 1, 12'h040, 32'h0BADCAFE, 4'hF, t, r, e);
    chk("t4_wr_T", t, 4);
    xfer(1, 0, 12'h040, 32'h0, 4'h0, t, r, e);
    chk("t4_rd_T", t, 5);
    chk("t4_rd_data", r, 32'h0BADCAFE);

    // penable without a setup phase must be ignored
    idle(1);
    psel0 = 1; penable = 1; pwrite = 1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1 idle(1);
    xfer(0, 0, 12'h010, 32'h0, 4'h0, t, r, e);
    chk("t5_noset_data", r, 32'hDEADBEEF);

    // psel dropped during write wait states
    idle(1);
    psel1 = 1; penable = 0; pwrite = 1; paddr = 12'h014; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel1 = 0; penable = 0;
    repeat (3) @(posedge clk);
    #1;
    xfer(1, 0, 12'h014, 32'h0, 4'h0, t, r, e);
    chk("t5_abort_mem", r, 32'hA500_0005);

    // reset in the middle of a read
    idle(1);
    psel1 = 1; penable = 0; pwrite = 0; paddr = 12'h040;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 rstn = 0; psel1 = 0; penable = 0;
    @(negedge clk);
    chk("t5_rst_pready", pready1, 1'b0);
    chk("t5_rst_pslverr", pslverr1, 1'b0);
    chk("t5_rst_prdata", prdata1, 32'h0);
    @(posedge clk); #1 rstn = 1;
    xfer(1, 0, 12'h040, 32'h0, 4'h0, t, r, e);
    chk("t5_post_rst1", r, 32'h0BADCAFE);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, t, r, e);
    chk("t5_post_rst0", r, 32'h11BB33DD);

    // random traffic across both instances
    for (int i = 0; i < 10000; i++) begin
      d = $urandom_range(0, 1);
      w = 1'($urandom_range(0, 1));
      a = {10'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom);
      xfer(d, w, a, $urandom, 4'($urandom), t, r, e);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
